// File: rtl/clint_trap_ctrl.sv
// Core-local trap/interrupt sequencer: writes mepc/mstatus/mcause, stalls, then redirects.
// Optional macro CLINT_ASYNC_INT_EN enables the asynchronous interrupt path.
module clint_trap_ctrl #(
    parameter int          INT_W        = 8,
    parameter logic [31:0] ECALL_CAUSE  = 32'd11,
    parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] int_flag_i,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_flag_i,
    input  logic             global_int_en_i,
    input  logic [31:0]      csr_mtvec_i,
    input  logic [31:0]      csr_mepc_i,
    input  logic [31:0]      csr_mstatus_i,
    output logic             we_o,
    output logic [31:0]      waddr_o,
    output logic [31:0]      data_o,
    output logic             hold_flag_o,
    output logic             int_assert_o,
    output logic [31:0]      int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    typedef enum logic [2:0] {
        S_IDLE, S_W_MEPC, S_W_MSTATUS, S_W_MCAUSE, S_ASSERT_TRAP, S_R_MSTATUS, S_ASSERT_MRET
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d, cause_q, cause_d;
    logic        is_ecall, is_ebreak, is_mret, accept;
    logic        async_req;
    logic [31:0] async_epc, async_cause;
    logic [31:0] mstatus_trap, mstatus_mret;

    assign is_ecall  = (inst_i == INST_ECALL);
    assign is_ebreak = (inst_i == INST_EBREAK);
    assign is_mret   = (inst_i == INST_MRET);
    // Events are only sampled in IDLE, out of reset, and when nobody else stalls the pipe.
    assign accept    = rst && (state_q == S_IDLE) && !hold_flag_i;

`ifdef CLINT_ASYNC_INT_EN
    assign async_req   = (|int_flag_i) && global_int_en_i;
    assign async_epc   = jump_flag_i ? jump_addr_i : inst_addr_i;
    assign async_cause = int_flag_i[0] ? 32'h8000_0007 : 32'h8000_000B;
`else
    logic unused_async;
    assign async_req    = 1'b0;
    assign async_epc    = 32'h0;
    assign async_cause  = 32'h0;
    assign unused_async = ^{int_flag_i, global_int_en_i, jump_flag_i, jump_addr_i};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            epc_q   <= 32'h0;
            cause_q <= 32'h0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_ecall || is_ebreak) begin
                        state_d = S_W_MEPC;
                        epc_d   = inst_addr_i;
                        cause_d = is_ecall ? ECALL_CAUSE : EBREAK_CAUSE;
                    end else if (is_mret) begin
                        state_d = S_R_MSTATUS;
                    end else if (async_req) begin
                        state_d = S_W_MEPC;
                        epc_d   = async_epc;
                        cause_d = async_cause;
                    end
                end
            end
            S_W_MEPC:      state_d = S_W_MSTATUS;
            S_W_MSTATUS:   state_d = S_W_MCAUSE;
            S_W_MCAUSE:    state_d = S_ASSERT_TRAP;
            S_R_MSTATUS:   state_d = S_ASSERT_MRET;
            default:       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mstatus_trap    = csr_mstatus_i;
        mstatus_trap[7] = csr_mstatus_i[3];
        mstatus_trap[3] = 1'b0;
        mstatus_mret    = csr_mstatus_i;
        mstatus_mret[3] = csr_mstatus_i[7];
        mstatus_mret[7] = 1'b1;

        we_o         = 1'b0;
        waddr_o      = 32'h0;
        data_o       = 32'h0;
        int_assert_o = 1'b0;
        int_addr_o   = 32'h0;
        // Stall starts combinationally in the detect cycle and covers the redirect cycle.
        hold_flag_o  = (state_q != S_IDLE) || (state_d != S_IDLE);
        case (state_q)
            S_W_MEPC: begin
                we_o    = 1'b1;
                waddr_o = CSR_MEPC;
                data_o  = epc_q;
            end
            S_W_MSTATUS: begin
                we_o    = 1'b1;
                waddr_o = CSR_MSTATUS;
                data_o  = mstatus_trap;
            end
            S_W_MCAUSE: begin
                we_o    = 1'b1;
                waddr_o = CSR_MCAUSE;
                data_o  = cause_q;
            end
            S_R_MSTATUS: begin
                we_o    = 1'b1;
                waddr_o = CSR_MSTATUS;
                data_o  = mstatus_mret;
            end
            S_ASSERT_TRAP: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mtvec_i;
            end
            S_ASSERT_MRET: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Scoreboard bench for clint_trap_ctrl: a transaction-level model predicts CSR writes and redirects.
module tb_clint_trap_ctrl;

    localparam int INT_W = 8;
    localparam logic [31:0] I_ECALL  = 32'h0000_0073;
    localparam logic [31:0] I_EBREAK = 32'h0010_0073;
    localparam logic [31:0] I_MRET   = 32'h3020_0073;
    localparam logic [31:0] I_NOP    = 32'h0000_0013;
`ifdef CLINT_ASYNC_INT_EN
    localparam bit ASYNC = 1'b1;
`else
    localparam bit ASYNC = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [INT_W-1:0] int_flag_i = '0;
    logic [31:0]      inst_i = I_NOP, inst_addr_i = '0, jump_addr_i = '0;
    logic             jump_flag_i = 1'b0, hold_flag_i = 1'b0, global_int_en_i = 1'b0;
    logic [31:0]      csr_mtvec_i = '0, csr_mepc_i = '0, csr_mstatus_i = '0;
    logic             we_o, hold_flag_o, int_assert_o;
    logic [31:0]      waddr_o, data_o, int_addr_o;

    clint_trap_ctrl #(.INT_W(INT_W)) dut (
        .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i), .global_int_en_i(global_int_en_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o), .hold_flag_o(hold_flag_o),
        .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_jmp;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   busy_left = 0;
    int   errors = 0;
    int   checks = 0;
    bit   exp_hold = 1'b0;

    task automatic push_exp(input bit j, input logic [31:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.is_jmp = j; e.addr = a; e.data = d; e.cyc = c;
        sbq.push_back(e);
    endtask

    // One clock of stimulus; the model decides what the sequencer must do in the following cycles.
    task automatic step(input logic r, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [7:0] irq, input logic mie, input logic jf,
                        input logic [31:0] ja, input logic hold, input logic [31:0] mtvec,
                        input logic [31:0] mepc, input logic [31:0] mstatus);
        logic        trap;
        logic [31:0] epc, cause, ms;
        @(posedge clk);
        #1;
        cyc++;
        rst = r; inst_i = inst; inst_addr_i = pc; int_flag_i = irq;
        global_int_en_i = mie; jump_flag_i = jf; jump_addr_i = ja; hold_flag_i = hold;
        if (busy_left == 0) begin
            csr_mtvec_i = mtvec; csr_mepc_i = mepc; csr_mstatus_i = mstatus;
        end
        ms = csr_mstatus_i;
        trap = 1'b0; epc = '0; cause = '0;
        if (busy_left > 0) begin
            exp_hold = 1'b1;
            busy_left--;
        end else if (!r || hold) begin
            exp_hold = 1'b0;
        end else if (inst == I_ECALL || inst == I_EBREAK) begin
            trap = 1'b1; epc = pc; cause = (inst == I_ECALL) ? 32'd11 : 32'd3;
        end else if (inst == I_MRET) begin
            push_exp(1'b0, 32'h300, (ms & ~32'h88) | (ms[7] ? 32'h8 : 32'h0) | 32'h80, cyc + 1);
            push_exp(1'b1, csr_mepc_i, 32'h0, cyc + 2);
            busy_left = 2;
            exp_hold = 1'b1;
        end else if (ASYNC && irq != 0 && mie) begin
            trap = 1'b1; epc = jf ? ja : pc;
            cause = irq[0] ? 32'h8000_0007 : 32'h8000_000B;
        end else begin
            exp_hold = 1'b0;
        end
        if (trap) begin
            push_exp(1'b0, 32'h341, epc, cyc + 1);
            push_exp(1'b0, 32'h300, (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0), cyc + 2);
            push_exp(1'b0, 32'h342, cause, cyc + 3);
            push_exp(1'b1, csr_mtvec_i, 32'h0, cyc + 4);
            busy_left = 4;
            exp_hold = 1'b1;
        end
        if (!r) begin
            busy_left = 0;
            while (sbq.size() > 0 && sbq[$].cyc > cyc) void'(sbq.pop_back());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, I_NOP, 32'h0, 8'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic check_zero(input string name);
        @(negedge clk);
        checks++;
        if ({we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o} != '0) begin
            errors++;
            $display("FAIL %s: we=%0b waddr=%h data=%h hold=%0b assert=%0b addr=%h, required all zero",
                     name, we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            checks++;
            if (hold_flag_o !== exp_hold) begin
                errors++;
                $display("FAIL hold cyc=%0d: got %0b, required %0b", cyc, hold_flag_o, exp_hold);
            end
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                checks++; errors++;
                mon_e = sbq.pop_front();
                $display("FAIL missing cyc=%0d: jmp=%0b addr=%h data=%h never seen",
                         mon_e.cyc, mon_e.is_jmp, mon_e.addr, mon_e.data);
            end
            if (we_o || int_assert_o) begin
                checks++;
                if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL unexpected cyc=%0d: we=%0b waddr=%h data=%h assert=%0b addr=%h, required none",
                             cyc, we_o, waddr_o, data_o, int_assert_o, int_addr_o);
                end else begin
                    mon_e = sbq.pop_front();
                    if (mon_e.is_jmp) begin
                        if (!(int_assert_o && !we_o && int_addr_o == mon_e.addr)) begin
                            errors++;
                            $display("FAIL redirect cyc=%0d: assert=%0b we=%0b addr=%h, required addr=%h",
                                     cyc, int_assert_o, we_o, int_addr_o, mon_e.addr);
                        end
                    end else if (!(we_o && !int_assert_o && waddr_o == mon_e.addr && data_o == mon_e.data)) begin
                        errors++;
                        $display("FAIL csr_write cyc=%0d: we=%0b waddr=%h data=%h, required waddr=%h data=%h",
                                 cyc, we_o, waddr_o, data_o, mon_e.addr, mon_e.data);
                    end
                end
            end else begin
                checks++;
                if (waddr_o != 0 || data_o != 0) begin
                    errors++;
                    $display("FAIL idle_bus cyc=%0d: waddr=%h data=%h, required 0", cyc, waddr_o, data_o);
                end
            end
        end
    end

    initial begin
        // Reset state
        step(1'b0, I_ECALL, 32'h40, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b0, 32'h200, 32'h0, 32'h8);
        check_zero("reset_outputs");
        step(1'b0, I_NOP, 32'h0, 8'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        idle(2);
        // ecall trap and mret return
        step(1'b1, I_ECALL, 32'h100, 8'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h200, 32'h0, 32'h8);
        idle(6);
        step(1'b1, I_MRET, 32'h200, 8'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h200, 32'h104, 32'h80);
        idle(4);
        // Async interrupts (timer with jump target, external without)
        step(1'b1, I_NOP, 32'h110, 8'h01, 1'b1, 1'b1, 32'h300, 1'b0, 32'h200, 32'h0, 32'h8);
        idle(6);
        step(1'b1, I_NOP, 32'h120, 8'h04, 1'b1, 1'b0, 32'h0, 1'b0, 32'h200, 32'h0, 32'h8);
        idle(6);
        // Masked and held-off requests
        step(1'b1, I_NOP, 32'h130, 8'h01, 1'b0, 1'b0, 32'h0, 1'b0, 32'h200, 32'h0, 32'h0);
        step(1'b1, I_ECALL, 32'h134, 8'h01, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 32'h0, 32'h8);
        idle(2);
        // ebreak wins over a simultaneous interrupt; interrupt ignored while busy
        step(1'b1, I_EBREAK, 32'h140, 8'h01, 1'b1, 1'b0, 32'h0, 1'b0, 32'h200, 32'h0, 32'h8);
        for (int i = 0; i < 4; i++)
            step(1'b1, I_NOP, 32'h144, 8'h01, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        idle(3);
        // Reset in the mstatus write cycle aborts the sequence
        step(1'b1, I_ECALL, 32'h150, 8'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h200, 32'h0, 32'h8);
        idle(1);
        step(1'b0, I_NOP, 32'h0, 8'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        idle(1);
        check_zero("reset_abort");
        idle(5);
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] inst;
            int k;
            k = $urandom_range(0, 9);
            inst = (k == 0) ? I_ECALL : (k == 1) ? I_EBREAK : (k == 2) ? I_MRET
                 : (I_NOP | ($urandom & 32'hFFFF_0000));
            step($urandom_range(0, 99) != 0, inst, $urandom & 32'hFFFF_FFFC,
                 ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0, 1'($urandom),
                 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 6) == 0,
                 $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom);
        end
        idle(8);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected transactions left, required 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clint_trap_ctrl.md
Name: clint_trap_ctrl

Overview:
- Core-local interrupt/trap sequencer between the execute stage and the CSR register file.
- Detects synchronous traps (ecall, ebreak), asynchronous interrupts and mret in the instruction at the execute stage.
- Drives the CSR file's clint write port to update mepc/mstatus/mcause, stalls the pipeline, then issues a one-cycle redirect to mtvec (trap) or mepc (mret).

Parameters:
- INT_W, 8, width of the interrupt request vector int_flag_i.
- ECALL_CAUSE, 32'd11, mcause value written for ecall.
- EBREAK_CAUSE, 32'd3, mcause value written for ebreak.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- int_flag_i  input  INT_W  interrupt requests, level; bit0 = timer, bits[INT_W-1:1] = external
- inst_i  input  32  instruction currently in execute
- inst_addr_i  input  32  PC of inst_i
- jump_flag_i  input  1  execute stage is redirecting this cycle
- jump_addr_i  input  32  redirect target from execute
- hold_flag_i  input  1  pipeline stalled by another source (divider, bus)
- global_int_en_i  input  1  mstatus.MIE from CSR file
- csr_mtvec_i  input  32  current mtvec
- csr_mepc_i  input  32  current mepc
- csr_mstatus_i  input  32  current mstatus
- we_o  output  1  CSR write enable, active-high
- waddr_o  output  32  CSR write address (upper 20 bits zero)
- data_o  output  32  CSR write data
- hold_flag_o  output  1  stall request to pipeline control
- int_assert_o  output  1  one-cycle redirect strobe
- int_addr_o  output  32  redirect target, valid only with int_assert_o

Behaviour:
- Reset (rst==0 at posedge clk): all outputs 0; FSM in IDLE; latched cause and epc 0. Reset mid-sequence aborts the sequence; no further CSR writes.
- Decode is exact 32-bit compare: ecall 0x00000073, ebreak 0x00100073, mret 0x30200073.
- Event priority in IDLE, sampled only when hold_flag_i==0:
  - 1. sync trap (ecall/ebreak), regardless of global_int_en_i.
  - 2. mret.
  - 3. async interrupt: int_flag_i!=0 and global_int_en_i==1.
- Latched values:
  - Sync trap: epc = inst_addr_i; cause = ECALL_CAUSE or EBREAK_CAUSE.
  - Async: epc = jump_flag_i ? jump_addr_i : inst_addr_i; cause = 0x80000007 if int_flag_i[0], else 0x8000000B.
- hold_flag_o is combinationally 1 in the detect cycle and stays 1 until the cycle after int_assert_o. With no event in IDLE it is 0.
- Trap FSM, one state per cycle:
  - IDLE -> W_MEPC: we_o=1, waddr_o=0x341, data_o=epc.
  - -> W_MSTATUS: waddr_o=0x300, data_o = csr_mstatus_i with bit7 (MPIE) = bit3 (old MIE), bit3 = 0.
  - -> W_MCAUSE: waddr_o=0x342, data_o=cause.
  - -> ASSERT: we_o=0, int_assert_o=1, int_addr_o=csr_mtvec_i.
  - -> IDLE.
  - Trap latency: detect to int_assert_o = 4 clocks.
- mret FSM:
  - IDLE -> R_MSTATUS: we_o=1, waddr_o=0x300, data_o = csr_mstatus_i with bit3 = bit7, bit7 = 1.
  - -> ASSERT: int_assert_o=1, int_addr_o=csr_mepc_i.
  - -> IDLE.
  - mret latency: 2 clocks.
- Outside write states, we_o=0 and waddr_o/data_o=0. int_assert_o is never high for more than one cycle.
- Events arriving while not IDLE are ignored (not queued). Async requests are level, so they are re-evaluated on return to IDLE.
- After a trap, MIE=0, so a still-asserted int_flag_i causes no re-entry until software or mret sets MIE.
- Simultaneous ecall and pending interrupt: ecall taken; cause 11.
- hold_flag_i==1 in IDLE: no event accepted that cycle.

Optional Feature:
- Macro CLINT_ASYNC_INT_EN.
- Defined: asynchronous interrupt path active as above.
- Undefined: int_flag_i and global_int_en_i are ignored; only ecall/ebreak/mret are handled; cause encodings 0x8000000x are never produced.

Test Plan:
- ecall at inst_addr 0x100, mtvec=0x200, mstatus=0x8: CSR writes mepc=0x100, mstatus=0x80, mcause=11 on consecutive cycles → int_assert_o=1, int_addr_o=0x200; hold_flag_o high for 5 cycles.
- mret with mepc=0x104, mstatus=0x80: write mstatus=0x88 → next cycle int_assert_o=1, int_addr_o=0x104.
- int_flag_i=0x01, MIE=1, jump_flag_i=1, jump_addr_i=0x300: mepc=0x300, mcause=0x80000007; repeat with int_flag_i=0x04 and no jump: mepc=inst_addr_i, mcause=0x8000000B.
- int_flag_i=0x01 with MIE=0, or hold_flag_i=1: no CSR write, no int_assert_o, hold_flag_o=0.
- ebreak and int_flag_i=0x01 in the same cycle with MIE=1: mcause=3; interrupt not taken while busy.
- rst=0 asserted during W_MSTATUS: next cycle all outputs 0, no W_MCAUSE write; with CLINT_ASYNC_INT_EN undefined, int_flag_i=0xFF never triggers.
